// File: rtl/mips_soc.sv
// Board top for the calculator demo: synchronised DIP/key inputs, 32-bit ALU,
// LED and multiplexed 7-segment display, and a UART TX that sends each new result.
module mips_soc #(
  parameter int unsigned CLK_FREQ = 250_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned SCAN_DIV = 1024
) (
  input  logic        clk_in,
  input  logic        sys_rstn,
  input  logic        uart_rxd,
  input  logic [7:0]  dip_switch0,
  input  logic [7:0]  dip_switch1,
  input  logic [7:0]  dip_switch2,
  input  logic [7:0]  dip_switch3,
  input  logic [7:0]  dip_switch4,
  input  logic [7:0]  dip_switch5,
  input  logic [7:0]  dip_switch6,
  input  logic [7:0]  dip_switch7,
  input  logic [7:0]  user_key,
  output logic        uart_txd,
  output logic [31:0] led_light,
  output logic [7:0]  digital_tube0,
  output logic [3:0]  digital_tube_sel0,
  output logic [7:0]  digital_tube1,
  output logic [3:0]  digital_tube_sel1,
  output logic [7:0]  digital_tube2,
  output logic        digital_tube_sel2
);

  localparam int unsigned BIT_DIV = CLK_FREQ / BAUD;
  localparam int unsigned BW      = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int unsigned SW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  logic unused_rxd;
  assign unused_rxd = uart_rxd;

  // ---------------- input synchronisers ----------------
  logic [71:0] raw_in, sync1_q, sync2_q;
  assign raw_in = {user_key, dip_switch7, dip_switch6, dip_switch5, dip_switch4,
                   dip_switch3, dip_switch2, dip_switch1, dip_switch0};

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  logic [31:0] opa, opb;
  logic [7:0]  keys;
  assign opa  = ~sync2_q[31:0];
  assign opb  = ~sync2_q[63:32];
  assign keys = ~sync2_q[71:64];

  // ---------------- operation select and ALU ----------------
  logic [2:0]  op_sel;
  logic        key_hit;
  logic [31:0] alu;

  always_comb begin
    op_sel  = '0;
    key_hit = |keys;
    // Scan from the top down so the lowest pressed key is the last writer.
    for (int unsigned i = 8; i > 0; i--) begin
      if (keys[i-1]) op_sel = 3'(i - 1);
    end
  end

  always_comb begin
    alu = '0;
    case (op_sel)
      3'd0: alu = opa + opb;
      3'd1: alu = opa - opb;
      3'd2: alu = opa * opb;
      3'd3: alu = (opb == '0) ? '1 : opa / opb;
      3'd4: alu = (opb == '0) ? opa : opa % opb;
      3'd5: alu = opa & opb;
      3'd6: alu = opa | opb;
      3'd7: alu = opa ^ opb;
      default: alu = '0;
    endcase
  end

  logic [31:0] result_q, result_d;
  logic [2:0]  op_q, op_d;

  always_comb begin
    result_d = result_q;
    op_d     = op_q;
    if (key_hit) begin
      result_d = alu;
      op_d     = op_sel;
    end
  end

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      result_q <= '0;
      op_q     <= '0;
    end else begin
      result_q <= result_d;
      op_q     <= op_d;
    end
  end

  assign led_light = ~result_q;

  // ---------------- 7-segment scan ----------------
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    scan_idx_q, scan_idx_d;

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = scan_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
    end
  end

  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0; 4'h1: s = 8'hF9; 4'h2: s = 8'hA4; 4'h3: s = 8'hB0;
      4'h4: s = 8'h99; 4'h5: s = 8'h92; 4'h6: s = 8'h82; 4'h7: s = 8'hF8;
      4'h8: s = 8'h80; 4'h9: s = 8'h90; 4'hA: s = 8'h88; 4'hB: s = 8'h83;
      4'hC: s = 8'hC6; 4'hD: s = 8'hA1; 4'hE: s = 8'h86; 4'hF: s = 8'h8E;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  logic [3:0] nib_lo, nib_hi;

  always_comb begin
    nib_lo = result_q[3:0];
    nib_hi = result_q[19:16];
    case (scan_idx_q)
      2'd1: begin nib_lo = result_q[7:4];   nib_hi = result_q[23:20]; end
      2'd2: begin nib_lo = result_q[11:8];  nib_hi = result_q[27:24]; end
      2'd3: begin nib_lo = result_q[15:12]; nib_hi = result_q[31:28]; end
      default: ;
    endcase
  end

  assign digital_tube0     = hex7(nib_lo);
  assign digital_tube1     = hex7(nib_hi);
  assign digital_tube2     = hex7({1'b0, op_q});
  assign digital_tube_sel0 = 4'b0001 << scan_idx_q;
  assign digital_tube_sel1 = 4'b0001 << scan_idx_q;
  assign digital_tube_sel2 = 1'b1;

  // ---------------- UART transmitter ----------------
  tx_state_e   tx_state_q, tx_state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [31:0] pkt_q, pkt_d;
  logic [31:0] last_q, last_d;
  logic        pend_q, pend_d;
  logic        txd_q, txd_d;
  logic        baud_tick;
  logic [7:0]  cur_byte_d;

  always_comb begin
    tx_state_d = tx_state_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    pkt_d      = pkt_q;
    last_d     = last_q;
    pend_d     = pend_q | (result_q != last_q);
    baud_tick  = (baud_q == BIT_LAST);
    baud_d     = baud_tick ? '0 : baud_q + 1'b1;

    case (tx_state_q)
      TX_IDLE: begin
        baud_d = '0;
        if (pend_q) begin
          pkt_d      = result_q;
          last_d     = result_q;
          pend_d     = 1'b0;
          byte_d     = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (baud_tick) begin
          bit_d      = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (baud_tick) begin
          if (bit_q == 3'd7) tx_state_d = TX_STOP;
          else               bit_d      = bit_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (baud_tick) begin
          if (byte_q == 2'd3) begin
            tx_state_d = TX_IDLE;
          end else begin
            byte_d     = byte_q + 1'b1;
            pkt_d      = {pkt_q[23:0], 8'h00};
            tx_state_d = TX_START;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // Line level is decoded from the next state so the pin comes straight off a flop.
    cur_byte_d = pkt_d[31:24];
    case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = cur_byte_d[bit_d];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      tx_state_q <= TX_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      pkt_q      <= '0;
      last_q     <= '0;
      pend_q     <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      pkt_q      <= pkt_d;
      last_q     <= last_d;
      pend_q     <= pend_d;
      txd_q      <= txd_d;
    end
  end

  assign uart_txd = txd_q;

endmodule

// File: tb/tb_mips_soc.sv
// Self-checking bench for mips_soc: directed scenarios plus random operands/keys,
// checked against an arithmetic reference and a bit-level UART receiver.
module tb_mips_soc;

  localparam int unsigned CLK_FREQ = 1000;
  localparam int unsigned BAUD     = 100;
  localparam int unsigned SCAN_DIV = 8;
  localparam int unsigned BIT_DIV  = CLK_FREQ / BAUD;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rxd = 1'b1;
  logic [7:0] sw0, sw1, sw2, sw3, sw4, sw5, sw6, sw7, key;
  logic uart_txd;
  logic [31:0] led;
  logic [7:0] tube0, tube1, tube2;
  logic [3:0] sel0, sel1;
  logic sel2;

  always #5 clk = ~clk;

  mips_soc #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .SCAN_DIV(SCAN_DIV)) dut (
    .clk_in(clk), .sys_rstn(rstn), .uart_rxd(rxd),
    .dip_switch0(sw0), .dip_switch1(sw1), .dip_switch2(sw2), .dip_switch3(sw3),
    .dip_switch4(sw4), .dip_switch5(sw5), .dip_switch6(sw6), .dip_switch7(sw7),
    .user_key(key), .uart_txd(uart_txd), .led_light(led),
    .digital_tube0(tube0), .digital_tube_sel0(sel0),
    .digital_tube1(tube1), .digital_tube_sel1(sel1),
    .digital_tube2(tube2), .digital_tube_sel2(sel2)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference state: what the result/op registers should hold once inputs settle.
  logic [31:0] m_res = '0;
  int          m_op  = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  rx_q  [$];
  int          chk_idx = 0;
  int          frame_err = 0;

  function automatic logic [31:0] ref_calc(input logic [31:0] a, input logic [31:0] b, input int op);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a * b;
      3: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4: return (b == 0) ? a : a % b;
      5: return a & b;
      6: return a | b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic int ref_op(input logic [7:0] pressed);
    for (int i = 0; i < 8; i++) if (pressed[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [7:0] pressed);
    int o;
    {sw3, sw2, sw1, sw0} = ~a;
    {sw7, sw6, sw5, sw4} = ~b;
    key = ~pressed;
    o = ref_op(pressed);
    if (o >= 0) begin
      m_res = ref_calc(a, b, o);
      m_op  = o;
    end
  endtask

  task automatic push_pkt(input logic [31:0] r);
    exp_q.push_back(r[31:24]);
    exp_q.push_back(r[23:16]);
    exp_q.push_back(r[15:8]);
    exp_q.push_back(r[7:0]);
  endtask

  task automatic check_uart(input string tag, input int budget);
    int n;
    n = 0;
    while (rx_q.size() < exp_q.size() && n < budget) begin
      tick(1);
      n++;
    end
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = chk_idx; i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hXXXX_XXXX,
          {24'h0, exp_q[i]});
    chk_idx = exp_q.size();
  endtask

  task automatic check_scan(input string tag);
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0;
      while (sel0 !== (4'b0001 << k) && n < 4 * SCAN_DIV + 4) begin
        tick(1);
        n++;
      end
      chk($sformatf("%s_sel0_%0d", tag, k), {28'h0, sel0}, 32'(4'b0001 << k));
      chk($sformatf("%s_sel1_%0d", tag, k), {28'h0, sel1}, 32'(4'b0001 << k));
      chk($sformatf("%s_tube0_%0d", tag, k), {24'h0, tube0}, {24'h0, font[m_res[4*k +: 4]]});
      chk($sformatf("%s_tube1_%0d", tag, k), {24'h0, tube1}, {24'h0, font[m_res[16+4*k +: 4]]});
    end
  endtask

  // UART receiver: centre-samples each bit of an 8N1 frame.
  initial begin
    int cnt;
    bit busy;
    logic [7:0] sh;
    busy = 0;
    cnt = 0;
    sh = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        busy = 0;
      end else if (!busy) begin
        if (uart_txd === 1'b0) begin
          busy = 1;
          cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt >= BIT_DIV / 2 && (cnt - BIT_DIV / 2) % BIT_DIV == 0) begin
          int k;
          k = (cnt - BIT_DIV / 2) / BIT_DIV;
          if (k == 0) begin
            if (uart_txd !== 1'b0) frame_err++;
          end else if (k <= 8) begin
            sh[k-1] = uart_txd;
          end else begin
            if (uart_txd !== 1'b1) frame_err++;
            rx_q.push_back(sh);
            busy = 0;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b, held;
    logic [7:0]  pk;
    int base, n;

    // Reset state
    apply('0, '0, 8'h00);
    tick(3);
    chk("rst_led", led, 32'hFFFF_FFFF);
    chk("rst_sel0", {28'h0, sel0}, 32'h1);
    chk("rst_sel1", {28'h0, sel1}, 32'h1);
    chk("rst_tube0", {24'h0, tube0}, 32'hC0);
    chk("rst_tube1", {24'h0, tube1}, 32'hC0);
    chk("rst_tube2", {24'h0, tube2}, 32'hC0);
    chk("rst_sel2", {31'h0, sel2}, 32'h1);
    chk("rst_txd", {31'h0, uart_txd}, 32'h1);
    rstn = 1'b1;
    tick(2);

    // Add with three-cycle latency
    apply(32'h0000_00C3, 32'h0000_0044, 8'h01);
    tick(2);
    chk("add_lat2", led, 32'hFFFF_FFFF);
    tick(1);
    chk("add_lat3", led, ~m_res);
    chk("add_led", led, 32'hFFFF_FEF8);
    chk("add_tube2", {24'h0, tube2}, {24'h0, font[m_op]});
    push_pkt(m_res);
    check_scan("add");

    // Result change while the first packet is on the wire
    apply(32'h0000_0012, 32'h0000_0044, 8'h01);
    tick(3);
    chk("add2_led", led, ~m_res);
    chk("add2_val", ~led, 32'h0000_0056);
    push_pkt(m_res);
    check_uart("pkt_add", 3000);
    tick(500);
    chk("pkt_add_quiet", rx_q.size(), 8);

    // Division and modulo by zero
    apply(32'd5, 32'd0, 8'h08);
    tick(3);
    chk("div0_led", led, ~m_res);
    chk("div0_val", ~led, 32'hFFFF_FFFF);
    chk("div0_tube2", {24'h0, tube2}, {24'h0, font[3]});
    push_pkt(m_res);
    tick(10);
    apply(32'd5, 32'd0, 8'h10);
    tick(3);
    chk("mod0_led", led, ~m_res);
    chk("mod0_val", ~led, 32'h0000_0005);
    chk("mod0_tube2", {24'h0, tube2}, {24'h0, font[4]});
    push_pkt(m_res);
    check_uart("pkt_div", 3000);

    // Two keys pressed, then release and hold
    apply(32'd3, 32'd5, 8'h06);
    tick(3);
    chk("prio_led", led, ~m_res);
    chk("prio_val", ~led, 32'hFFFF_FFFE);
    chk("prio_tube2", {24'h0, tube2}, {24'h0, font[1]});
    push_pkt(m_res);
    apply(32'd3, 32'd5, 8'h00);
    tick(3);
    apply($urandom, $urandom, 8'h00);
    tick(5);
    chk("hold_led", led, ~32'hFFFF_FFFE);
    check_scan("hold");
    check_uart("pkt_prio", 3000);

    // Random operands and key patterns
    base = rx_q.size();
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 300)));
      pk = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      apply(a, b, pk);
      tick(5);
      chk($sformatf("rnd%0d_led", i), led, ~m_res);
      chk($sformatf("rnd%0d_tube2", i), {24'h0, tube2}, {24'h0, font[m_op]});
    end
    tick(1500);
    if (rx_q.size() > base) begin
      chk("rnd_pkt_align", (rx_q.size() - base) % 4, 0);
      chk("rnd_pkt_last", {rx_q[rx_q.size()-4], rx_q[rx_q.size()-3], rx_q[rx_q.size()-2], rx_q[rx_q.size()-1]}, m_res);
    end
    chk_idx = rx_q.size();
    exp_q = rx_q;

    // Reset in the middle of a UART byte
    held = m_res;
    a = $urandom;
    b = $urandom;
    if ((a ^ b) == held) b = b ^ 32'h1;
    apply(a, b, 8'h80);
    n = 0;
    while (uart_txd !== 1'b0 && n < 200) begin
      tick(1);
      n++;
    end
    chk("abort_start", {31'h0, uart_txd}, 32'h0);
    tick(35);
    rstn = 1'b0;
    #1;
    chk("abort_txd", {31'h0, uart_txd}, 32'h1);
    chk("abort_led", led, 32'hFFFF_FFFF);
    chk("abort_sel0", {28'h0, sel0}, 32'h1);
    m_res = '0;
    m_op = 0;
    apply('0, '0, 8'h00);
    tick(3);
    base = rx_q.size();
    rstn = 1'b1;
    tick(800);
    chk("abort_quiet", rx_q.size(), base);
    chk("abort_idle_txd", {31'h0, uart_txd}, 32'h1);
    chk("abort_led_after", led, ~m_res);
    chk("abort_tube2", {24'h0, tube2}, {24'h0, font[m_op]});
    chk("frame_errors", frame_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
